// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator and registered VGA pixel output stage
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 2,
  parameter int PIPE_DLY  = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_ce,
  output logic       frame_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_ACT_END  = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  // {act, hs, vs} while nothing is being displayed
  localparam logic [2:0] TIM_IDLE = 3'b011;

  // Counters are 10 bits wide, so larger rasters cannot be represented
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIX_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
  endgenerate

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             act;
  logic             hs_i;
  logic             vs_i;
  logic [2:0]       tim_now;
  logic [2:0]       tim_dly;

  assign div_next = (div == DIV_LAST) ? '0 : div + 1'b1;

  // Pixel divider; pixel_ce is registered so it is low during and right after reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div      <= '0;
      pixel_ce <= 1'b0;
    end else begin
      div      <= div_next;
      pixel_ce <= (div_next == DIV_LAST);
    end
  end

  // Raster counters advance one position per pixel tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pixel_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  assign act  = ({1'b0, hc} < H_ACT_END) && ({1'b0, vc} < V_ACT_END);
  assign hs_i = !(({1'b0, hc} >= H_SYNC_BEG) && ({1'b0, hc} < H_SYNC_END));
  assign vs_i = !(({1'b0, vc} >= V_SYNC_BEG) && ({1'b0, vc} < V_SYNC_END));

  assign frame_start = pixel_ce && (hc == H_LAST) && (vc == V_LAST);
  assign tim_now     = {act, hs_i, vs_i};

  // Delay the timing flags by the mapper latency so they meet the matching colour
  generate
    if (PIPE_DLY == 0) begin : g_no_pipe
      assign tim_dly = tim_now;
    end else begin : g_pipe
      logic [2:0] stage [PIPE_DLY];

      // Shift register stepped once per pixel tick
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          for (int i = 0; i < PIPE_DLY; i++) stage[i] <= TIM_IDLE;
        end else if (pixel_ce) begin
          stage[0] <= tim_now;
          for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
        end
      end

      assign tim_dly = stage[PIPE_DLY-1];
    end
  endgenerate

  // Final pin register; blanking forces the colour to black
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pixel_ce) begin
      VGA_BLANK_N <= tim_dly[2];
      VGA_HS      <= tim_dly[1];
      VGA_VS      <= tim_dly[0];
      VGA_R       <= tim_dly[2] ? Red   : 8'h00;
      VGA_G       <= tim_dly[2] ? Green : 8'h00;
      VGA_B       <= tim_dly[2] ? Blue  : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int DIV0 = 2, DLY0 = 0;
  localparam int DIV1 = 1, DLY1 = 2;
  localparam int FRAME0 = HT * VT * DIV0;
  localparam logic [26:0] IDLE_REC = {1'b0, 1'b1, 1'b1, 24'h0};

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] red [2], green [2], blue [2];
  logic [7:0] vga_r [2], vga_g [2], vga_b [2];
  logic [9:0] draw_x [2], draw_y [2];
  logic       pce [2], fs [2], hs [2], vs [2], blank [2];

  int npass = 0;
  int ntot  = 0;

  int          tick [2];
  int          n_edges;
  logic [26:0] exp_pin [2];
  logic [26:0] q0 [$];
  logic [26:0] q1 [$];
  logic        prev_blank;
  logic [7:0]  prev_r;
  int          fall_seen;

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] map_col(input logic m, input logic [9:0] x, input logic [9:0] y);
    if (m) return 24'hFFFFFF;
    return {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
  endfunction

  function automatic logic [26:0] exp_rec(input logic m, input int h, input int v);
    logic a, eh, ev;
    a  = (h < HV) && (v < VV);
    eh = !((h >= HV + HF) && (h < HV + HF + HS));
    ev = !((v >= VV + VF) && (v < VV + VF + VS));
    return {a, eh, ev, a ? map_col(m, 10'(h), 10'(v)) : 24'h0};
  endfunction

  function automatic logic exp_pce(input int k, input int n);
    int d;
    d = (k == 0) ? DIV0 : DIV1;
    return (n >= 1) && ((n % d) == d - 1);
  endfunction

  // Combinational colour mapper for dut0, two-tick pipelined mapper for dut1
  assign {red[0], green[0], blue[0]} = map_col(mode, draw_x[0], draw_y[0]);

  logic [23:0] m1_d1, m1_d2;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m1_d1 <= '0;
      m1_d2 <= '0;
    end else if (pce[1]) begin
      m1_d1 <= map_col(mode, draw_x[1], draw_y[1]);
      m1_d2 <= m1_d1;
    end
  end
  assign {red[1], green[1], blue[1]} = m1_d2;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(DIV0), .PIPE_DLY(DLY0)
  ) dut0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red(red[0]), .Green(green[0]), .Blue(blue[0]),
    .DrawX(draw_x[0]), .DrawY(draw_y[0]),
    .pixel_ce(pce[0]), .frame_start(fs[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(blank[0]),
    .VGA_R(vga_r[0]), .VGA_G(vga_g[0]), .VGA_B(vga_b[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(DIV1), .PIPE_DLY(DLY1)
  ) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red(red[1]), .Green(green[1]), .Blue(blue[1]),
    .DrawX(draw_x[1]), .DrawY(draw_y[1]),
    .pixel_ce(pce[1]), .frame_start(fs[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(blank[1]),
    .VGA_R(vga_r[1]), .VGA_G(vga_g[1]), .VGA_B(vga_b[1])
  );

  task automatic init_model();
    n_edges = 0;
    tick[0] = 0;
    tick[1] = 0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < DLY0; i++) q0.push_back(IDLE_REC);
    for (int i = 0; i < DLY1; i++) q1.push_back(IDLE_REC);
    exp_pin[0] = IDLE_REC;
    exp_pin[1] = IDLE_REC;
    prev_blank = 1'b0;
    prev_r     = 8'h00;
  endtask

  task automatic release_reset();
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    init_model();
  endtask

  task automatic run_sb(input int ncyc);
    logic [26:0] r, obs;
    logic        pre [2];
    logic        epce, efs;
    int          h, v;
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < 2; k++) pre[k] = exp_pce(k, n_edges);
      @(posedge Clk);
      for (int k = 0; k < 2; k++) begin
        if (pre[k]) begin
          h = tick[k] % HT;
          v = (tick[k] / HT) % VT;
          r = exp_rec(mode, h, v);
          if (k == 0) begin
            q0.push_back(r);
            exp_pin[0] = q0.pop_front();
          end else begin
            q1.push_back(r);
            exp_pin[1] = q1.pop_front();
          end
          tick[k]++;
        end
      end
      n_edges++;
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        h    = tick[k] % HT;
        v    = (tick[k] / HT) % VT;
        epce = exp_pce(k, n_edges);
        efs  = epce && (h == HT - 1) && (v == VT - 1);
        ntot++;
        if (draw_x[k] !== 10'(h) || draw_y[k] !== 10'(v))
          $display("FAIL draw_xy dut%0d edge %0d: got (%0d,%0d) expected (%0d,%0d)", k, n_edges, draw_x[k], draw_y[k], h, v);
        else npass++;
        ntot++;
        if ({pce[k], fs[k]} !== {epce, efs})
          $display("FAIL ce_fs dut%0d edge %0d: got ce=%b fs=%b expected ce=%b fs=%b", k, n_edges, pce[k], fs[k], epce, efs);
        else npass++;
        obs = {blank[k], hs[k], vs[k], vga_r[k], vga_g[k], vga_b[k]};
        ntot++;
        if (obs !== exp_pin[k])
          $display("FAIL pins dut%0d edge %0d: got %h expected %h", k, n_edges, obs, exp_pin[k]);
        else npass++;
        if (!blank[k]) begin
          ntot++;
          if ({vga_r[k], vga_g[k], vga_b[k]} !== 24'h0)
            $display("FAIL blank_rgb dut%0d edge %0d: got %h expected 000000", k, n_edges, {vga_r[k], vga_g[k], vga_b[k]});
          else npass++;
        end
      end
      if (!mode && prev_blank && !blank[0]) begin
        fall_seen++;
        ntot++;
        if (prev_r !== 8'(HV - 1))
          $display("FAIL blank_fall_r: got %0d expected %0d", prev_r, HV - 1);
        else npass++;
      end
      prev_blank = blank[0];
      prev_r     = vga_r[0];
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [26:0] obs;
    for (int k = 0; k < 2; k++) begin
      obs = {blank[k], hs[k], vs[k], vga_r[k], vga_g[k], vga_b[k]};
      ntot++;
      if (draw_x[k] !== 10'd0 || draw_y[k] !== 10'd0)
        $display("FAIL %s_xy dut%0d: got (%0d,%0d) expected (0,0)", tag, k, draw_x[k], draw_y[k]);
      else npass++;
      ntot++;
      if ({pce[k], fs[k]} !== 2'b00)
        $display("FAIL %s_ce_fs dut%0d: got %b%b expected 00", tag, k, pce[k], fs[k]);
      else npass++;
      ntot++;
      if (obs !== IDLE_REC)
        $display("FAIL %s_pins dut%0d: got %h expected %h", tag, k, obs, IDLE_REC);
      else npass++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    check_reset_state("reset");
    Reset_n = 1'b1;
    init_model();
  endtask

  task automatic test_alignment();
    fall_seen = 0;
    run_sb(2 * FRAME0 + 20);
    ntot++;
    if (fall_seen == 0) $display("FAIL blank_fall_seen: got 0 expected >0");
    else npass++;
  endtask

  task automatic test_line_timing();
    logic [9:0] prev;
    bit         found;
    int         cnt, fall, low;
    found = 0;
    prev  = draw_x[0];
    for (int i = 0; i < 4 * HT * DIV0 && !found; i++) begin
      @(negedge Clk);
      if (draw_x[0] == 10'd0 && prev != 10'd0) found = 1;
      prev = draw_x[0];
    end
    ntot++;
    if (!found) $display("FAIL line_start: got timeout expected hc wrap");
    else npass++;
    cnt  = 0;
    fall = -1;
    for (int i = 0; i < 4 * HT * DIV0 && fall < 0; i++) begin
      @(negedge Clk);
      cnt++;
      if (hs[0] === 1'b0) fall = cnt;
    end
    ntot++;
    if (fall !== 2 * (HV + HF + 1)) $display("FAIL hs_fall_delay: got %0d expected %0d", fall, 2 * (HV + HF + 1));
    else npass++;
    low = 0;
    for (int i = 0; i < 4 * HT * DIV0 && hs[0] === 1'b0; i++) begin
      @(negedge Clk);
      low++;
    end
    ntot++;
    if (low !== 2 * HS) $display("FAIL hs_low_width: got %0d expected %0d", low, 2 * HS);
    else npass++;
  endtask

  task automatic test_frame_period();
    int  per, low, rows_seen, max_y;
    bit  found;
    logic seen [VT];
    found = 0;
    for (int i = 0; i < 2 * FRAME0 && !found; i++) begin
      @(negedge Clk);
      if (fs[0] === 1'b1) found = 1;
    end
    for (int r = 0; r < VT; r++) seen[r] = 1'b0;
    per   = 0;
    max_y = 0;
    found = 0;
    for (int i = 0; i < 2 * FRAME0 && !found; i++) begin
      @(negedge Clk);
      per++;
      if (int'(draw_y[0]) > max_y) max_y = int'(draw_y[0]);
      if (draw_y[0] < 10'(VT)) seen[draw_y[0]] = 1'b1;
      if (fs[0] === 1'b1) found = 1;
    end
    ntot++;
    if (per !== FRAME0) $display("FAIL frame_period: got %0d expected %0d", per, FRAME0);
    else npass++;
    rows_seen = 0;
    for (int r = 0; r < VT; r++) if (seen[r]) rows_seen++;
    ntot++;
    if (rows_seen !== VT || max_y !== VT - 1)
      $display("FAIL drawy_cover: got rows=%0d max=%0d expected rows=%0d max=%0d", rows_seen, max_y, VT, VT - 1);
    else npass++;
    found = 0;
    for (int i = 0; i < 2 * FRAME0 && !found; i++) begin
      @(negedge Clk);
      if (vs[0] === 1'b0) found = 1;
    end
    low = 0;
    for (int i = 0; i < 2 * FRAME0 && vs[0] === 1'b0; i++) begin
      @(negedge Clk);
      low++;
    end
    ntot++;
    if (low !== 2 * HT * VS) $display("FAIL vs_low_width: got %0d expected %0d", low, 2 * HT * VS);
    else npass++;
  endtask

  task automatic test_blanking();
    mode    = 1'b1;
    Reset_n = 1'b0;
    release_reset();
    run_sb(FRAME0 + 40);
  endtask

  task automatic test_async_reset();
    bit found;
    mode  = 1'b0;
    found = 0;
    for (int i = 0; i < 2 * FRAME0 && !found; i++) begin
      @(negedge Clk);
      if (draw_x[0] == 10'(HV + HF + 1) && draw_y[0] == 10'(VV + VF)) found = 1;
    end
    ntot++;
    if (!found || hs[0] !== 1'b0 || vs[0] !== 1'b0)
      $display("FAIL mid_frame_sync: got found=%0d hs=%b vs=%b expected found=1 hs=0 vs=0", found, hs[0], vs[0]);
    else npass++;
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_state("async");
    release_reset();
    run_sb(FRAME0 + 40);
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_line_timing();
    test_frame_period();
    test_blanking();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
